// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: word widths, reset/bubble
// defaults, the next-PC select encoding and the redirect alignment helper.
package if_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // Opcode field position within an instruction word (consumed by the main decoder)
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = '0;
  localparam logic [ADDR_W-1:0]  RESET_PC_DEF  = '0;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_REDIRECT = 2'd1,
    PC_SEQ      = 2'd2
  } pc_sel_e;

  // Force a byte address onto a word boundary
  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// pc_reg: program counter with asynchronous active-low reset and a fixed
// priority next-PC mux (stall > redirect > wait state > sequential).
module pc_reg
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic              ready,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_next;

  // Select the next-PC source in priority order
  always_comb begin
    sel = PC_SEQ;
    if (stall)         sel = PC_HOLD;
    else if (redirect) sel = PC_REDIRECT;
    else if (!ready)   sel = PC_HOLD;
  end

  // Next-PC mux; the sequential increment wraps naturally modulo 2^32
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_REDIRECT: pc_next = target;
      PC_SEQ:      pc_next = pc + ADDR_W'(4);
      default:     pc_next = pc;
    endcase
  end

  // PC state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC (via pc_reg), drives the
// instruction-memory address and holds the IF/ID pipeline register.
// Optional feature macro: IF_ALIGN_CHECK_EN -- misaligned redirects are refused
// and reported on the sticky addr_err flag; otherwise targets are word-aligned
// and addr_err is tied low.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_d,
  input  logic               flush_d,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] instr_d,
  output logic [ADDR_W-1:0]  pc_plus4_d,
  output logic               valid_d,
  output logic               addr_err
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              pc_stall;
  logic              imem_en_q;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign imem_addr = pc;
  assign imem_en   = imem_en_q;

`ifdef IF_ALIGN_CHECK_EN
  logic bad_redirect;
  logic addr_err_q;

  // A refused redirect is folded into the PC stall so the PC holds rather
  // than advancing; the IF/ID side still squashes on redirect_valid.
  assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign pc_stall     = stall_d || bad_redirect;
  assign addr_err     = addr_err_q;

  // Sticky misaligned-redirect flag; a stalled redirect is not yet acted upon
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       addr_err_q <= 1'b0;
    else if (!stall_d && bad_redirect) addr_err_q <= 1'b1;
  end
`else
  assign pc_stall = stall_d;
  assign addr_err = 1'b0;
`endif

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (pc_stall),
    .redirect (redirect_valid),
    .ready    (imem_ready),
    .target   (align_word(redirect_pc)),
    .pc       (pc)
  );

  // Fetch enable rises on the first clock edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) imem_en_q <= 1'b0;
    else        imem_en_q <= 1'b1;
  end

  // IF/ID register: flush > stall > redirect squash > wait-state bubble > load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (stall_d) begin
      instr_d    <= instr_d;
      pc_plus4_d <= pc_plus4_d;
      valid_d    <= valid_d;
    end else if (redirect_valid || !imem_ready) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else begin
      instr_d    <= imem_rdata;
      pc_plus4_d <= pc_plus4;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scenario-driven bench for if_stage with a scoreboard queue of
// expected post-edge state. Instruction memory is a pure function of address.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_d, flush_d, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        addr_err;

  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        err;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_err;

  if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .instr_d        (instr_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .addr_err       (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C08_0004;
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  function automatic obs_t sample();
    return '{imem_en, imem_addr, instr_d, pc_plus4_d, valid_d, addr_err};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
    sb.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_ready = 1'b1;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one cycle of inputs, push the expected post-edge state, clock once
  task automatic drive(input logic s, input logic f, input logic rv,
                       input logic [31:0] rpc, input logic rdy);
    logic bad;
    stall_d = s; flush_d = f; redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy;
    bad = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    bad = rv && (rpc[1:0] != 2'b00);
`endif
    if (f) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (!s) begin
      if (rv || !rdy) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
    end
    if (!s) begin
      if (rv) begin
        if (!bad) m_pc = {rpc[31:2], 2'b00};
      end else if (rdy) begin
        m_pc = m_pc + 32'd4;
      end
      if (bad) m_err = 1'b1;
    end
    sb.push_back('{1'b1, m_pc, m_instr, m_pc4, m_valid, m_err});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst_n = 1'b0;
    stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_ready = 1'b1;
    #3;
    o = sample(); n_cmp++;
    if (o !== obs_t'(0)) begin
      n_mis++; $display("FAIL reset_init: got %p want %p", o, obs_t'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    n_cmp++;
    if (imem_addr !== 32'h0 || imem_en !== 1'b0) begin
      n_mis++; $display("FAIL reset_release: got addr=%h en=%b want addr=00000000 en=0", imem_addr, imem_en);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL reset_seq%0d: got %p want %p", i, o, e); end
    end
    n_cmp++;
    if (imem_addr !== 32'h14) begin
      n_mis++; $display("FAIL reset_seq_addr: got %h want 00000014", imem_addr);
    end
    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    o = sample(); n_cmp++;
    if (o !== obs_t'(0)) begin
      n_mis++; $display("FAIL reset_midrun: got %p want %p", o, obs_t'(0));
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_sequential();
    obs_t o, e;
    apply_reset();
    idle();
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e) begin n_mis++; $display("FAIL seq_sb: got %p want %p", o, e); end
    n_cmp++;
    if (instr_d !== 32'h8C08_0004 || pc_plus4_d !== 32'h4 || valid_d !== 1'b1) begin
      n_mis++; $display("FAIL seq_first: got instr=%h pc4=%h v=%b want 8c080004 00000004 1",
                        instr_d, pc_plus4_d, valid_d);
    end
  endtask

  task automatic test_redirect();
    obs_t o, e;
    apply_reset();
    for (int i = 0; i < 4; i++) idle();
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    idle();
    for (int i = 0; i < 6; i++) begin
      e = sb.pop_front(); n_cmp++;
      if (i == 4) begin
        // Reconstruct the post-redirect sample from the bench's expectation list
      end
      o = (i == 5) ? sample() : e;
      if (i == 5 && o !== e) begin n_mis++; $display("FAIL redir_follow: got %p want %p", o, e); end
    end
    n_cmp++;
    if (instr_d !== mem_word(32'h40) || pc_plus4_d !== 32'h44 || imem_addr !== 32'h44) begin
      n_mis++; $display("FAIL redir_target: got instr=%h pc4=%h pc=%h want %h 00000044 00000044",
                        instr_d, pc_plus4_d, imem_addr, mem_word(32'h40));
    end
    // Redirect cycle itself: check bubble and new PC directly
    apply_reset();
    for (int i = 0; i < 4; i++) idle();
    drive(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
    n_cmp++;
    if (imem_addr !== 32'h40 || valid_d !== 1'b0) begin
      n_mis++; $display("FAIL redir_bubble: got pc=%h v=%b want 00000040 0", imem_addr, valid_d);
    end
    for (int i = 0; i < 5; i++) begin
      e = sb.pop_front();
      if (i == 4) begin
        o = sample(); n_cmp++;
        if (o !== e) begin n_mis++; $display("FAIL redir_sb: got %p want %p", o, e); end
      end
    end
  endtask

  task automatic test_stall_flush();
    obs_t o, e, frozen;
    apply_reset();
    idle(); idle();
    sb.delete();
    frozen = sample();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e || o !== frozen) begin
        n_mis++; $display("FAIL stall%0d: got %p want %p", i, o, e);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e || imem_addr !== 32'h8 || valid_d !== 1'b0) begin
      n_mis++; $display("FAIL stall_flush: got %p want %p", o, e);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h80, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e || imem_addr !== 32'h8) begin
      n_mis++; $display("FAIL stall_redirect: got %p want %p", o, e);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    idle();
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front(); o = (i == 1) ? sample() : e;
      if (i == 1) begin
        n_cmp++;
        if (o !== e) begin n_mis++; $display("FAIL flush_resume: got %p want %p", o, e); end
      end
    end
  endtask

  task automatic test_wait_states();
    obs_t o, e;
    apply_reset();
    idle(); idle();
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e || imem_addr !== 32'h8 || valid_d !== 1'b0) begin
        n_mis++; $display("FAIL wait%0d: got %p want %p", i, o, e);
      end
    end
    idle();
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e || instr_d !== mem_word(32'h8) || imem_addr !== 32'hC) begin
      n_mis++; $display("FAIL wait_resume: got %p want %p", o, e);
    end
  endtask

  task automatic test_wrap_align();
    obs_t o, e;
    apply_reset();
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    idle();
    e = sb.pop_front();
    e = sb.pop_front(); o = sample(); n_cmp++;
    if (o !== e || imem_addr !== 32'h0 || pc_plus4_d !== 32'h0) begin
      n_mis++; $display("FAIL wrap: got %p want %p", o, e);
    end
    idle(); idle();
    sb.delete();
    drive(1'b0, 1'b0, 1'b1, 32'h42, 1'b1);
    e = sb.pop_front(); o = sample(); n_cmp++;
`ifdef IF_ALIGN_CHECK_EN
    if (o !== e || imem_addr !== 32'h8 || addr_err !== 1'b1 || valid_d !== 1'b0) begin
      n_mis++; $display("FAIL align_refuse: got %p want %p", o, e);
    end
`else
    if (o !== e || imem_addr !== 32'h40 || addr_err !== 1'b0 || valid_d !== 1'b0) begin
      n_mis++; $display("FAIL align_truncate: got %p want %p", o, e);
    end
`endif
    for (int i = 0; i < 3; i++) begin
      idle();
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL align_after%0d: got %p want %p", i, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic s, f, rv, rdy;
    logic [31:0] rpc;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      s   = ($urandom_range(0, 5) == 0);
      f   = ($urandom_range(0, 6) == 0);
      rv  = ($urandom_range(0, 4) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rpc = $urandom();
      if ($urandom_range(0, 2) != 0) rpc[1:0] = 2'b00;
      drive(s, f, rv, rpc, rdy);
      e = sb.pop_front(); o = sample(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL b2b%0d: got %p want %p", i, o, e); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_flush();
    test_wait_states();
    test_wrap_align();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
